btn_event_ctrl: RTL and testbench



---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_event_sync.sv | 27 ++
 rtl/btn_event_ctrl.sv | 158 +++++++++++++++
 tb/tb_btn_event_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button event controller.
package btn_pkg;

  // Press / long-press / auto-repeat states.
  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLongHeld
  } btn_state_e;

  // Defaults for a 27 MHz system clock.
  localparam int unsigned DbCyclesDef   = 270000;    // 10 ms
  localparam int unsigned LongCyclesDef = 27000000;  // 1 s
  localparam int unsigned RepCyclesDef  = 5400000;   // 200 ms

  // Short timings used by the bench.
  localparam int unsigned TbDbCycles   = 4;
  localparam int unsigned TbLongCycles = 20;
  localparam int unsigned TbRepCycles  = 8;

endpackage

// File: rtl/btn_event_sync.sv
// Two-flop synchroniser for an asynchronous input with a configurable reset level.
module btn_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Chain of two flops; the first may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Push-button front end: synchronise, debounce, then press / long-press / auto-repeat events.
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DbCyclesDef,
  parameter int unsigned LONG_CYCLES = LongCyclesDef,
  parameter int unsigned REP_CYCLES  = RepCyclesDef,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic held
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES);
  localparam int unsigned LongW = $clog2(LONG_CYCLES);
  localparam int unsigned RepW  = $clog2(REP_CYCLES);

  localparam logic [DbW-1:0]   DbMax   = DbW'(DB_CYCLES - 1);
  localparam logic [LongW-1:0] LongMax = LongW'(LONG_CYCLES - 1);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REP_CYCLES - 1);

  logic sync_raw;
  logic sync_pressed;

  // Sync flops idle at the released pin level so reset never looks like a press.
  btn_sync #(
    .ResetVal (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_in),
    .q_o   (sync_raw)
  );

  assign sync_pressed = ACTIVE_LOW ? ~sync_raw : sync_raw;

  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;

  // Debounce next state: count cycles of disagreement, toggle once it has lasted DB_CYCLES.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_pressed != level_q) begin
      if (db_cnt_q == DbMax) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  btn_state_e       state_q, state_d;
  logic [LongW-1:0] hold_q, hold_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic press_q, press_d, release_q, release_d, long_q, long_d;
  logic repeat_q, repeat_d, step_q, step_d, held_q, held_d;

  // Event FSM next state; a released level is checked first so release beats timer expiry.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q) begin
          state_d = StPressed;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      StPressed: begin
        if (!level_q) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (hold_q == LongMax) begin
          state_d  = StLongHeld;
          long_d   = 1'b1;
          repeat_d = 1'b1;
          rep_d    = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StLongHeld: begin
        if (!level_q) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else if (rep_q == RepMax) begin
          repeat_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    step_d = press_d | repeat_d;
    held_d = (state_d == StLongHeld);
  end

  // FSM state, timers and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      rep_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
      held_q    <= held_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;
  assign held          = held_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with a scoreboard of expected pulse cycles.
module tb_btn_event_ctrl;
  import btn_pkg::*;

  localparam logic [4:0] EvPress   = 5'b10001;  // {press, release, long, repeat, step}
  localparam logic [4:0] EvRelease = 5'b01000;
  localparam logic [4:0] EvLong    = 5'b00111;
  localparam logic [4:0] EvRepeat  = 5'b00011;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse, held;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned step_cnt = 0;
  int unsigned c, d, s0;
  ev_t sb_q[$];

  btn_event_ctrl #(
    .DB_CYCLES   (TbDbCycles),
    .LONG_CYCLES (TbLongCycles),
    .REP_CYCLES  (TbRepCycles),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .step_pulse    (step_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned at, input logic [4:0] kind);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Every pulse the DUT emits must match the next scoreboard entry in cycle and kind.
  always @(negedge clk) begin
    logic [4:0] v;
    ev_t e;
    v = {press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse};
    if (step_pulse === 1'b1) step_cnt++;
    if (v !== 5'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {27'b0, v}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_kind", {27'b0, v}, {27'b0, e.kind});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with a chattering pin, then release reset with the button up.
    rst_n  = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      btn_in = 1'($urandom_range(0, 1));
      check("reset_outputs", {25'b0, btn_level, press_pulse, release_pulse, long_pulse,
                              repeat_pulse, step_pulse, held}, 32'h0);
    end
    @(negedge clk);
    btn_in = 1'b1;
    rst_n  = 1'b1;
    c = cyc;
    wait_until(c + 10);
    check("idle_level", {31'b0, btn_level}, 32'h0);

    // 2: glitch shorter than the debounce window.
    btn_in = 1'b0;
    c = cyc;
    wait_until(c + 3);
    btn_in = 1'b1;
    for (int i = 4; i <= 12; i += 4) begin
      wait_until(c + i);
      check("glitch_level", {31'b0, btn_level}, 32'h0);
    end

    // 3: short press and release.
    c = cyc;
    btn_in = 1'b0;
    push(c + 7, EvPress);
    wait_until(c + 5);
    check("press_level_early", {31'b0, btn_level}, 32'h0);
    wait_until(c + 6);
    check("press_level_rise", {31'b0, btn_level}, 32'h1);
    wait_until(c + 12);
    btn_in = 1'b1;
    d = cyc;
    push(d + 7, EvRelease);
    wait_until(d + 5);
    check("release_level_early", {31'b0, btn_level}, 32'h1);
    wait_until(d + 6);
    check("release_level_fall", {31'b0, btn_level}, 32'h0);
    wait_until(d + 12);

    // 4: long press with auto-repeat, released between repeats.
    c = cyc;
    s0 = step_cnt;
    btn_in = 1'b0;
    push(c + 7, EvPress);
    push(c + 27, EvLong);
    for (int k = 1; k <= 4; k++) push(c + 27 + 8 * k, EvRepeat);
    wait_until(c + 26);
    check("held_before_long", {31'b0, held}, 32'h0);
    wait_until(c + 27);
    check("held_at_long", {31'b0, held}, 32'h1);
    wait_until(c + 50);
    check("held_mid", {31'b0, held}, 32'h1);
    wait_until(c + 58);
    btn_in = 1'b1;
    push(c + 65, EvRelease);
    wait_until(c + 64);
    check("held_before_release", {31'b0, held}, 32'h1);
    wait_until(c + 65);
    check("held_after_release", {31'b0, held}, 32'h0);
    wait_until(c + 75);
    check("step_count", step_cnt - s0, 32'd6);

    // 5: release lands exactly when a repeat is due; release must win.
    c = cyc;
    btn_in = 1'b0;
    push(c + 7, EvPress);
    push(c + 27, EvLong);
    for (int k = 1; k <= 4; k++) push(c + 27 + 8 * k, EvRepeat);
    wait_until(c + 60);
    btn_in = 1'b1;
    push(c + 67, EvRelease);
    wait_until(c + 67);
    check("race_held", {31'b0, held}, 32'h0);
    wait_until(c + 76);
    check("race_level", {31'b0, btn_level}, 32'h0);

    // 6: reset during LONG_HELD with the button still down.
    c = cyc;
    btn_in = 1'b0;
    push(c + 7, EvPress);
    push(c + 27, EvLong);
    push(c + 35, EvRepeat);
    wait_until(c + 40);
    check("held_before_reset", {31'b0, held}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {25'b0, btn_level, press_pulse, release_pulse, long_pulse,
                               repeat_pulse, step_pulse, held}, 32'h0);
    wait_until(c + 43);
    rst_n = 1'b1;
    d = cyc;
    push(d + 7, EvPress);
    push(d + 27, EvLong);
    push(d + 35, EvRepeat);
    push(d + 43, EvRepeat);
    wait_until(d + 6);
    check("repress_level", {31'b0, btn_level}, 32'h1);
    wait_until(d + 40);
    btn_in = 1'b1;
    push(d + 47, EvRelease);
    wait_until(d + 46);
    check("reheld", {31'b0, held}, 32'h1);
    wait_until(d + 56);
    check("reheld_cleared", {31'b0, held}, 32'h0);

    check("scoreboard_drained", sb_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
